ext_bus_arbiter: RTL and testbench

- Shares one next-level memory port (block-wide command/address/data bus into the test memory controller) between two L1 cache requesters, e.g. the instruction and data caches of a 2-stage core.
- Each requester gets a one-entry command buffer. Buffered commands are granted round-robin and issued downstream.
- Block-fill responses return only to the requester that issued the read.
- Only one read is outstanding at a time. Writebacks are fire-and-forget.

---
 rtl/ext_bus_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_ext_bus_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_bus_arbiter.sv
// Two-requester round-robin arbiter sharing one block-wide memory port, with one read in flight.
// Optional performance counters are compiled in when EXT_BUS_ARB_PERF_EN is defined.
module ext_bus_arbiter #(
  parameter int BW_USED_ADDR_WORD    = 24,
  parameter int BW_DATA_EXTERNAL_BUS = 512,
  parameter int BW_CACHE_COMMAND     = 3,
  parameter logic [BW_CACHE_COMMAND-1:0] CMD_READ  = 3'b000,
  parameter logic [BW_CACHE_COMMAND-1:0] CMD_WRITE = 3'b001
) (
  input  logic                            clock_i,
  input  logic                            reset_i,
  input  logic                            req0_write_i,
  input  logic [BW_CACHE_COMMAND-1:0]     req0_command_i,
  input  logic [BW_USED_ADDR_WORD-1:0]    req0_addr_i,
  input  logic [BW_DATA_EXTERNAL_BUS-1:0] req0_data_i,
  output logic                            req0_full_o,
  input  logic                            req1_write_i,
  input  logic [BW_CACHE_COMMAND-1:0]     req1_command_i,
  input  logic [BW_USED_ADDR_WORD-1:0]    req1_addr_i,
  input  logic [BW_DATA_EXTERNAL_BUS-1:0] req1_data_i,
  output logic                            req1_full_o,
  output logic                            rsp0_write_o,
  output logic [BW_CACHE_COMMAND-1:0]     rsp0_command_o,
  output logic [BW_USED_ADDR_WORD-1:0]    rsp0_addr_o,
  output logic [BW_DATA_EXTERNAL_BUS-1:0] rsp0_data_o,
  input  logic                            rsp0_full_i,
  output logic                            rsp1_write_o,
  output logic [BW_CACHE_COMMAND-1:0]     rsp1_command_o,
  output logic [BW_USED_ADDR_WORD-1:0]    rsp1_addr_o,
  output logic [BW_DATA_EXTERNAL_BUS-1:0] rsp1_data_o,
  input  logic                            rsp1_full_i,
  output logic                            mem_write_o,
  output logic [BW_CACHE_COMMAND-1:0]     mem_command_o,
  output logic [BW_USED_ADDR_WORD-1:0]    mem_addr_o,
  output logic [BW_DATA_EXTERNAL_BUS-1:0] mem_data_o,
  input  logic                            mem_full_i,
  input  logic                            mem_write_i,
  input  logic [BW_CACHE_COMMAND-1:0]     mem_command_i,
  input  logic [BW_USED_ADDR_WORD-1:0]    mem_addr_i,
  input  logic [BW_DATA_EXTERNAL_BUS-1:0] mem_data_i,
  output logic                            mem_full_o,
`ifdef EXT_BUS_ARB_PERF_EN
  input  logic [1:0]                      perf_sel_i,
  input  logic                            perf_clear_i,
  output logic [31:0]                     perf_o,
`endif
  output logic                            error_o
);

  typedef logic [BW_CACHE_COMMAND-1:0]     cmd_t;
  typedef logic [BW_USED_ADDR_WORD-1:0]    addr_t;
  typedef logic [BW_DATA_EXTERNAL_BUS-1:0] data_t;
  typedef enum logic {IDLE = 1'b0, WAIT_RSP = 1'b1} state_t;

  state_t     state, state_nx;
  logic [1:0] req_write, buf_vld;
  cmd_t       req_cmd[2], buf_cmd[2];
  addr_t      req_addr[2], buf_addr[2];
  data_t      req_data[2], buf_data[2];
  logic       rr, owner, grant, issue, rsp_acc, err_set;

  // Every code other than CMD_READ, including CMD_WRITE, is fire-and-forget.
  function automatic logic wants_rsp(input cmd_t cmd);
    return (cmd == CMD_READ) && (cmd != CMD_WRITE);
  endfunction

  assign req_write   = {req1_write_i, req0_write_i};
  assign req_cmd[0]  = req0_command_i;
  assign req_cmd[1]  = req1_command_i;
  assign req_addr[0] = req0_addr_i;
  assign req_addr[1] = req1_addr_i;
  assign req_data[0] = req0_data_i;
  assign req_data[1] = req1_data_i;
  assign req0_full_o = buf_vld[0];
  assign req1_full_o = buf_vld[1];
  assign mem_full_o  = (state == WAIT_RSP) && (owner ? rsp1_full_i : rsp0_full_i);

  // Command buffers: capture on push, free on issue
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      buf_vld <= '0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (issue && (grant == 1'(n)))
          buf_vld[n] <= 1'b0;
        else if (req_write[n] && !buf_vld[n])
          buf_vld[n] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    for (int n = 0; n < 2; n++) begin
      if (req_write[n] && !buf_vld[n]) begin
        buf_cmd[n]  <= req_cmd[n];
        buf_addr[n] <= req_addr[n];
        buf_data[n] <= req_data[n];
      end
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    grant    = rr;
    rsp_acc  = 1'b0;
    err_set  = 1'b0;
    case (state)
      IDLE: begin
        err_set = mem_write_i;
        if ((buf_vld != 2'b00) && !mem_full_i) begin
          issue = 1'b1;
          grant = (buf_vld == 2'b11) ? rr : buf_vld[1];
          if (wants_rsp(buf_cmd[grant])) state_nx = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (mem_write_i && !mem_full_o) begin
          rsp_acc  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Output stage: strobes, arbitration pointer, owner and sticky error
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      rr           <= 1'b0;
      owner        <= 1'b0;
      mem_write_o  <= 1'b0;
      rsp0_write_o <= 1'b0;
      rsp1_write_o <= 1'b0;
      error_o      <= 1'b0;
    end else begin
      mem_write_o  <= issue;
      rsp0_write_o <= rsp_acc && !owner;
      rsp1_write_o <= rsp_acc && owner;
      if (issue) begin
        rr <= ~grant;
        if (wants_rsp(buf_cmd[grant])) owner <= grant;
      end
      if (err_set) error_o <= 1'b1;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      mem_command_o  <= '0;
      mem_addr_o     <= '0;
      mem_data_o     <= '0;
      rsp0_command_o <= '0;
      rsp0_addr_o    <= '0;
      rsp0_data_o    <= '0;
      rsp1_command_o <= '0;
      rsp1_addr_o    <= '0;
      rsp1_data_o    <= '0;
    end else begin
      if (issue) begin
        mem_command_o <= buf_cmd[grant];
        mem_addr_o    <= buf_addr[grant];
        mem_data_o    <= buf_data[grant];
      end
      if (rsp_acc && !owner) begin
        rsp0_command_o <= mem_command_i;
        rsp0_addr_o    <= mem_addr_i;
        rsp0_data_o    <= mem_data_i;
      end
      if (rsp_acc && owner) begin
        rsp1_command_o <= mem_command_i;
        rsp1_addr_o    <= mem_addr_i;
        rsp1_data_o    <= mem_data_i;
      end
    end
  end

`ifdef EXT_BUS_ARB_PERF_EN
  logic [31:0] grant0_cnt, grant1_cnt, wait_cnt;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      grant0_cnt <= '0;
      grant1_cnt <= '0;
      wait_cnt   <= '0;
    end else if (perf_clear_i) begin
      grant0_cnt <= '0;
      grant1_cnt <= '0;
      wait_cnt   <= '0;
    end else begin
      grant0_cnt <= sat_inc(grant0_cnt, issue && !grant);
      grant1_cnt <= sat_inc(grant1_cnt, issue && grant);
      wait_cnt   <= sat_inc(wait_cnt, state == WAIT_RSP);
    end
  end

  always_comb begin
    perf_o = '0;
    case (perf_sel_i)
      2'd0:    perf_o = grant0_cnt;
      2'd1:    perf_o = grant1_cnt;
      2'd2:    perf_o = wait_cnt;
      default: perf_o = '0;
    endcase
  end
`else
  // Performance counters compiled out.
`endif

endmodule

// File: tb/tb_ext_bus_arbiter.sv
// Bench for ext_bus_arbiter: directed scenarios then randomized traffic against a
// transaction-level reference model; immediate assertions at every comparison.
module tb_ext_bus_arbiter;
  localparam int AW = 24;
  localparam int DW = 512;
  localparam int CW = 3;
  localparam logic [CW-1:0] RD = 3'b000;
  localparam logic [CW-1:0] WR = 3'b001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          r_wr[2];
  logic [CW-1:0] r_cmd[2];
  logic [AW-1:0] r_addr[2];
  logic [DW-1:0] r_data[2];
  logic          rsp_full[2];
  logic          mem_full_in, mem_wr_in;
  logic [CW-1:0] mem_cmd_in;
  logic [AW-1:0] mem_addr_in;
  logic [DW-1:0] mem_data_in;

  logic          req0_full, req1_full, rsp0_wr, rsp1_wr, mem_write_o, mem_full_o, error_o;
  logic [CW-1:0] rsp0_cmd, rsp1_cmd, mem_command_o;
  logic [AW-1:0] rsp0_addr, rsp1_addr, mem_addr_o;
  logic [DW-1:0] rsp0_data, rsp1_data, mem_data_o;

  ext_bus_arbiter dut (
    .clock_i(clk), .reset_i(rst),
    .req0_write_i(r_wr[0]), .req0_command_i(r_cmd[0]), .req0_addr_i(r_addr[0]),
    .req0_data_i(r_data[0]), .req0_full_o(req0_full),
    .req1_write_i(r_wr[1]), .req1_command_i(r_cmd[1]), .req1_addr_i(r_addr[1]),
    .req1_data_i(r_data[1]), .req1_full_o(req1_full),
    .rsp0_write_o(rsp0_wr), .rsp0_command_o(rsp0_cmd), .rsp0_addr_o(rsp0_addr),
    .rsp0_data_o(rsp0_data), .rsp0_full_i(rsp_full[0]),
    .rsp1_write_o(rsp1_wr), .rsp1_command_o(rsp1_cmd), .rsp1_addr_o(rsp1_addr),
    .rsp1_data_o(rsp1_data), .rsp1_full_i(rsp_full[1]),
    .mem_write_o(mem_write_o), .mem_command_o(mem_command_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_full_i(mem_full_in),
    .mem_write_i(mem_wr_in), .mem_command_i(mem_cmd_in), .mem_addr_i(mem_addr_in),
    .mem_data_i(mem_data_in), .mem_full_o(mem_full_o),
    .error_o(error_o)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: pending command per requester, one outstanding read, expected outputs.
  bit            m_pv[2];
  logic [CW-1:0] m_pcmd[2];
  logic [AW-1:0] m_paddr[2];
  logic [DW-1:0] m_pdata[2];
  int            m_rr, m_owner;
  bit            m_busy, m_err;
  bit            e_mem_wr;
  logic [CW-1:0] e_mem_cmd;
  logic [AW-1:0] e_mem_addr;
  logic [DW-1:0] e_mem_data;
  bit            e_rsp_wr[2];
  logic [CW-1:0] e_rsp_cmd[2];
  logic [AW-1:0] e_rsp_addr[2];
  logic [DW-1:0] e_rsp_data[2];

  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      m_pv[n] = 0; e_rsp_wr[n] = 0;
      e_rsp_cmd[n] = '0; e_rsp_addr[n] = '0; e_rsp_data[n] = '0;
    end
    m_rr = 0; m_owner = 0; m_busy = 0; m_err = 0;
    e_mem_wr = 0; e_mem_cmd = '0; e_mem_addr = '0; e_mem_data = '0;
  endtask

  task automatic model_edge();
    bit pv_old[2];
    bit backpressure;
    int g;
    pv_old = m_pv;
    e_mem_wr = 0; e_rsp_wr[0] = 0; e_rsp_wr[1] = 0;
    backpressure = m_busy && rsp_full[m_owner];
    if (!m_busy) begin
      if (mem_wr_in) m_err = 1;
      if ((m_pv[0] || m_pv[1]) && !mem_full_in) begin
        g = (m_pv[0] && m_pv[1]) ? m_rr : (m_pv[1] ? 1 : 0);
        e_mem_wr = 1; e_mem_cmd = m_pcmd[g]; e_mem_addr = m_paddr[g]; e_mem_data = m_pdata[g];
        m_pv[g] = 0;
        m_rr = 1 - g;
        if (m_pcmd[g] == RD) begin m_busy = 1; m_owner = g; end
      end
    end else if (mem_wr_in && !backpressure) begin
      e_rsp_wr[m_owner] = 1;
      e_rsp_cmd[m_owner] = mem_cmd_in; e_rsp_addr[m_owner] = mem_addr_in;
      e_rsp_data[m_owner] = mem_data_in;
      m_busy = 0;
    end
    for (int n = 0; n < 2; n++)
      if (r_wr[n] && !pv_old[n]) begin
        m_pv[n] = 1; m_pcmd[n] = r_cmd[n]; m_paddr[n] = r_addr[n]; m_pdata[n] = r_data[n];
      end
  endtask

  task automatic compare_all();
    chk("mem_write_o", mem_write_o, e_mem_wr);
    chk("mem_command_o", mem_command_o, e_mem_cmd);
    chk("mem_addr_o", mem_addr_o, e_mem_addr);
    chk("mem_data_o", mem_data_o, e_mem_data);
    chk("rsp0_write_o", rsp0_wr, e_rsp_wr[0]);
    chk("rsp0_command_o", rsp0_cmd, e_rsp_cmd[0]);
    chk("rsp0_addr_o", rsp0_addr, e_rsp_addr[0]);
    chk("rsp0_data_o", rsp0_data, e_rsp_data[0]);
    chk("rsp1_write_o", rsp1_wr, e_rsp_wr[1]);
    chk("rsp1_command_o", rsp1_cmd, e_rsp_cmd[1]);
    chk("rsp1_addr_o", rsp1_addr, e_rsp_addr[1]);
    chk("rsp1_data_o", rsp1_data, e_rsp_data[1]);
    chk("req0_full_o", req0_full, m_pv[0]);
    chk("req1_full_o", req1_full, m_pv[1]);
    chk("error_o", error_o, m_err);
  endtask

  // Entered one time unit after a rising edge with inputs already set; leaves at the same phase.
  task automatic step();
    #1;
    chk("mem_full_o", mem_full_o, m_busy && rsp_full[m_owner]);
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    for (int n = 0; n < 2; n++) begin
      r_wr[n] = 0; r_cmd[n] = '0; r_addr[n] = '0; r_data[n] = '0; rsp_full[n] = 0;
    end
    mem_full_in = 0; mem_wr_in = 0; mem_cmd_in = '0; mem_addr_in = '0; mem_data_in = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1;
    #1;
    model_reset();
    compare_all();
    chk("rst_mem_full_o", mem_full_o, 0);
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  function automatic logic [DW-1:0] rand_blk();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [CW-1:0] rand_cmd();
    case ($urandom_range(0, 3))
      0, 1:    return RD;
      2:       return WR;
      default: return 3'b110;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] pat_a5;
    pat_a5 = {64{8'hA5}};
    rst = 0;
    idle_inputs();
    @(posedge clk);
    #1;
    apply_reset();

    // Single read on req0 with a block-fill response
    r_wr[0] = 1; r_cmd[0] = RD; r_addr[0] = 24'h000040; r_data[0] = rand_blk();
    step();
    r_wr[0] = 0;
    chk("t1_full0_set", req0_full, 1);
    chk("t1_no_early_issue", mem_write_o, 0);
    step();
    chk("t1_issue", mem_write_o, 1);
    chk("t1_issue_addr", mem_addr_o, 24'h000040);
    chk("t1_issue_cmd", mem_command_o, RD);
    chk("t1_full0_clear", req0_full, 0);
    step(); step();
    mem_wr_in = 1; mem_cmd_in = RD; mem_addr_in = 24'h000040; mem_data_in = pat_a5;
    step();
    mem_wr_in = 0;
    chk("t1_rsp0", rsp0_wr, 1);
    chk("t1_rsp0_data", rsp0_data, pat_a5);
    chk("t1_rsp1_quiet", rsp1_wr, 0);
    step();
    chk("t1_rsp0_single", rsp0_wr, 0);

    // Simultaneous reads: req0 first, req1 after req0's response
    apply_reset();
    r_wr[0] = 1; r_cmd[0] = RD; r_addr[0] = 24'h000200; r_data[0] = rand_blk();
    r_wr[1] = 1; r_cmd[1] = RD; r_addr[1] = 24'h000300; r_data[1] = rand_blk();
    step();
    r_wr[0] = 0; r_wr[1] = 0;
    step();
    chk("t2_first_issue", mem_write_o, 1);
    chk("t2_first_addr", mem_addr_o, 24'h000200);
    step(); step();
    chk("t2_hold_second", mem_write_o, 0);
    mem_wr_in = 1; mem_cmd_in = RD; mem_addr_in = 24'h000200; mem_data_in = rand_blk();
    step();
    mem_wr_in = 0;
    chk("t2_rsp0", rsp0_wr, 1);
    chk("t2_no_issue_on_rsp", mem_write_o, 0);
    step();
    chk("t2_second_issue", mem_write_o, 1);
    chk("t2_second_addr", mem_addr_o, 24'h000300);
    step();
    mem_wr_in = 1; mem_cmd_in = RD; mem_addr_in = 24'h000300; mem_data_in = rand_blk();
    step();
    mem_wr_in = 0;
    chk("t2_rsp1", rsp1_wr, 1);
    chk("t2_rsp0_quiet", rsp0_wr, 0);

    // Writebacks from req1, then pointer order checks with both requesters
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      r_wr[1] = 1; r_cmd[1] = WR; r_addr[1] = 24'h000100 + 24'(i * 16); r_data[1] = rand_blk();
      step();
      r_wr[1] = 0;
      step();
      chk("t3_wb_issue", mem_write_o, 1);
      chk("t3_wb_addr", mem_addr_o, 24'h000100 + 24'(i * 16));
      chk("t3_wb_cmd", mem_command_o, WR);
    end
    r_wr[0] = 1; r_cmd[0] = WR; r_addr[0] = 24'h000500; r_data[0] = rand_blk();
    r_wr[1] = 1; r_cmd[1] = WR; r_addr[1] = 24'h000600; r_data[1] = rand_blk();
    step();
    r_wr[0] = 0; r_wr[1] = 0;
    step();
    chk("t3_b2b_first", mem_addr_o, 24'h000500);
    step();
    chk("t3_b2b_second_pulse", mem_write_o, 1);
    chk("t3_b2b_second", mem_addr_o, 24'h000600);
    r_wr[0] = 1; r_cmd[0] = RD; r_addr[0] = 24'h000700; r_data[0] = rand_blk();
    r_wr[1] = 1; r_cmd[1] = RD; r_addr[1] = 24'h000800; r_data[1] = rand_blk();
    step();
    r_wr[0] = 0; r_wr[1] = 0;
    step();
    chk("t3_rr_read_first", mem_addr_o, 24'h000700);
    mem_wr_in = 1; mem_data_in = rand_blk();
    step();
    mem_wr_in = 0;
    step();
    chk("t3_rr_read_second", mem_addr_o, 24'h000800);
    mem_wr_in = 1; mem_data_in = rand_blk();
    step();
    mem_wr_in = 0;
    chk("t3_rsp1", rsp1_wr, 1);

    // Response backpressure from requester 0
    apply_reset();
    r_wr[0] = 1; r_cmd[0] = RD; r_addr[0] = 24'h000040; r_data[0] = rand_blk();
    step();
    r_wr[0] = 0;
    step();
    rsp_full[0] = 1; mem_wr_in = 1; mem_cmd_in = RD; mem_addr_in = 24'h000040;
    mem_data_in = rand_blk();
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t4_mem_full", mem_full_o, 1);
      chk("t4_rsp_held", rsp0_wr, 0);
    end
    rsp_full[0] = 0;
    step();
    mem_wr_in = 0;
    chk("t4_delivered", rsp0_wr, 1);
    chk("t4_mem_full_drop", mem_full_o, 0);

    // Unsolicited response while idle
    apply_reset();
    mem_wr_in = 1; mem_data_in = rand_blk();
    step();
    mem_wr_in = 0;
    chk("t5_error_set", error_o, 1);
    chk("t5_no_rsp0", rsp0_wr, 0);
    chk("t5_no_rsp1", rsp1_wr, 0);
    repeat (3) step();
    chk("t5_error_sticky", error_o, 1);

    // Reset while a read is outstanding and req1's buffer is occupied
    apply_reset();
    r_wr[0] = 1; r_cmd[0] = RD; r_addr[0] = 24'h000040; r_data[0] = rand_blk();
    step();
    r_wr[0] = 0;
    step();
    r_wr[1] = 1; r_cmd[1] = WR; r_addr[1] = 24'h000900; r_data[1] = rand_blk();
    step();
    r_wr[1] = 0;
    chk("t6_full1_before", req1_full, 1);
    apply_reset();
    chk("t6_full0_after", req0_full, 0);
    chk("t6_full1_after", req1_full, 0);
    chk("t6_mem_write_after", mem_write_o, 0);
    mem_wr_in = 1; mem_data_in = rand_blk();
    step();
    mem_wr_in = 0;
    chk("t6_late_error", error_o, 1);
    chk("t6_late_not_fwd", rsp0_wr, 0);
    step();
    chk("t6_discarded", mem_write_o, 0);

    // Randomized traffic against the model
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int n = 0; n < 2; n++) begin
        r_wr[n] = ($urandom_range(0, 2) == 0);
        r_cmd[n] = rand_cmd();
        r_addr[n] = AW'($urandom);
        r_data[n] = rand_blk();
        rsp_full[n] = ($urandom_range(0, 3) == 0);
      end
      mem_full_in = ($urandom_range(0, 4) == 0);
      mem_wr_in = m_busy && ($urandom_range(0, 2) == 0);
      mem_cmd_in = CW'($urandom);
      mem_addr_in = AW'($urandom);
      mem_data_in = rand_blk();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
